// File: rtl/seq_divider_pkg.sv
// Shared widths, counter sizing and state encoding for the sequential divider.
package seq_divider_pkg;

    localparam int DVD_W_DEF = 8;
    localparam int DVS_W_DEF = 4;
    localparam int CNT_W     = $clog2(DVD_W_DEF) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step
    import seq_divider_pkg::*;
#(
    parameter int DVS_W = DVS_W_DEF
) (
    input  logic [DVS_W:0]   r,
    input  logic             bit_in,
    input  logic [DVS_W-1:0] divisor,
    output logic [DVS_W:0]   r_next,
    output logic             q_bit
);

    logic [DVS_W:0] t;
    logic           r_msb_unused;

    // r < divisor always holds on entry, so its top bit is zero and drops out of t.
    assign r_msb_unused = r[DVS_W];

    always_comb begin
        t      = {r[DVS_W-1:0], bit_in};
        q_bit  = (t >= {1'b0, divisor});
        r_next = q_bit ? (t - {1'b0, divisor}) : t;
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider, one quotient bit per clock, start/done handshake.
//
// state | meaning
// IDLE  | ready for a new request; outputs hold the last result
// RUN   | one restoring step per edge until all dividend bits are consumed
// DONE  | single-cycle done pulse; results valid from this cycle
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int DVD_W = DVD_W_DEF,
    parameter int DVS_W = DVS_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder,
    output logic             div_by_zero
);

    // Never narrower than the package default, widened if DVD_W is overridden.
    localparam int CW = ($clog2(DVD_W) + 1 > CNT_W) ? $clog2(DVD_W) + 1 : CNT_W;

    state_t           state, next_state;
    logic [DVD_W-1:0] dvd_sh;
    logic [DVS_W-1:0] dvs_hold;
    logic [DVS_W:0]   r, r_next;
    logic [DVD_W-1:0] q_work;
    logic [CW-1:0]    count;
    logic             q_bit;
    logic             last_step;

    div_step #(.DVS_W(DVS_W)) u_step (
        .r       (r),
        .bit_in  (dvd_sh[DVD_W-1]),
        .divisor (dvs_hold),
        .r_next  (r_next),
        .q_bit   (q_bit)
    );

    assign last_step = (count == CW'(DVD_W - 1));
    assign ready     = (state == IDLE);
    assign done      = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_sh      <= '0;
            dvs_hold    <= '0;
            r           <= '0;
            q_work      <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor != '0) begin
                            dvd_sh   <= dividend;
                            dvs_hold <= divisor;
                            r        <= '0;
                            q_work   <= '0;
                            count    <= '0;
                        end else begin
                            quotient    <= '1;
                            remainder   <= '0;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    dvd_sh <= dvd_sh << 1;
                    r      <= r_next;
                    q_work <= {q_work[DVD_W-2:0], q_bit};
                    count  <= count + CW'(1);
                    // Outputs change only here, so they never show a partial result.
                    if (last_step) begin
                        quotient    <= {q_work[DVD_W-2:0], q_bit};
                        remainder   <= r_next[DVS_W-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative restoring unsigned divider. It is the inverse companion of the team's 4x4 combinational multiplier: it takes an 8-bit product-sized dividend and a 4-bit divisor, and returns quotient and remainder.
- Computes one quotient bit per clock, under a start/done handshake.
- Sits beside the multiplier so a bench or datapath can round-trip a*b back to a and b.

Parameters:
- DVD_W, 8, dividend and quotient width.
- DVS_W, 4, divisor and remainder width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when ready=1.
- dividend  input  DVD_W  unsigned dividend; captured on the accepting edge.
- divisor  input  DVS_W  unsigned divisor; captured on the accepting edge.
- ready  output  1  high in IDLE only.
- done  output  1  one-cycle pulse; results valid from this cycle.
- quotient  output  DVD_W  registered quotient.
- remainder  output  DVS_W  registered remainder.
- div_by_zero  output  1  registered flag for the last result.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, quotient=0, remainder=0, div_by_zero=0, done=0, ready=1, internal shift/partial/count registers=0.
- States: IDLE, RUN, DONE. ready = (state==IDLE). done = (state==DONE).
- IDLE, start=1 at edge E0, divisor!=0:
  - capture dividend into the shift register and divisor into a hold register.
  - partial remainder r (DVS_W+1 bits)=0, count=0, go to RUN.
- IDLE, start=1 at edge E0, divisor==0:
  - go directly to DONE.
  - quotient={DVD_W{1}}, remainder=0, div_by_zero=1.
  - done is high between E0 and E1.
- RUN, each edge E1..E8 does one restoring step:
  - t = {r[DVS_W-1:0], dividend MSB}; shift the dividend register left by one.
  - if t >= divisor: r = t - divisor, quotient bit = 1; else r = t, quotient bit = 0.
  - shift the quotient bit into the LSB of the working quotient; count++.
- At E8 (count reaches DVD_W):
  - load the quotient/remainder outputs from the working registers; remainder = r[DVS_W-1:0].
  - div_by_zero=0, go to DONE.
- Latency: done is high in the single cycle between E8 and E9, i.e. DVD_W cycles after the accepting edge.
- DONE: unconditionally return to IDLE on the next edge.
- Outputs hold their last result until the next result is loaded; they are never updated mid-RUN.
- start while RUN or DONE is ignored; no queuing. Inputs may change freely after E0.
- Back-to-back operation: start held high is re-accepted at the first edge after DONE (ready=1). Throughput is one result per DVD_W+2 cycles.
- Arithmetic invariants:
  - r < divisor holds before every shift, so t fits in DVS_W+1 bits.
  - the final remainder always satisfies remainder < divisor.
  - dividend = quotient*divisor + remainder must hold.
- rst_n asserted mid-RUN aborts immediately to reset values. No done pulse is emitted for the aborted operation.

Decomposition:
- Package seq_divider_pkg holds:
  - DVD_W and DVS_W defaults.
  - the state enum (IDLE, RUN, DONE).
  - the counter width localparam: clog2(DVD_W)+1.
- One combinational sub-module, div_step:
  - inputs: r, dividend bit, divisor.
  - outputs: next r, quotient bit.
  - reusable for a future unrolled version.

Test Plan:
- 255/15 accepted at E0 -> done high only between E8 and E9; quotient=17, remainder=0, div_by_zero=0; ready low during E1..E9.
- 200/7 -> quotient=28, remainder=4. Then 5/9 -> quotient=0, remainder=5. Outputs hold 28/4 until the 5/9 done pulse.
- 100/0 -> done high between E0 and E1; quotient=8'hFF, remainder=0, div_by_zero=1. A following 12/3 -> quotient=4, remainder=0, div_by_zero=0.
- start pulsed with 9/3 at E3 of an active 200/7 -> ignored; result stays 28/4 with a single done pulse.
- rst_n low at E4 of a 255/15 -> all outputs 0, ready=1, no done pulse. A fresh 81/9 after release -> quotient=9, remainder=0.
- Exhaustive sweep, dividend 0..255 x divisor 1..15:
  - check quotient/remainder against / and %, and check a*b round trips through myMultiplier.
  - print the test count and error count; 3840 tests with 0 errors required.
